// File: rtl/dmi_req_bridge.sv
// Bridges DTM requests to the debug module's DMI port. Requests are queued in a small
// FIFO, at most one DMI transaction is in flight, NOPs are answered locally, and hung
// transactions are failed after a timeout.
module dmi_req_bridge #(
  parameter int unsigned REQ_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dtm_req_valid,
  output logic        dtm_req_ready,
  input  logic [6:0]  dtm_req_addr,
  input  logic [1:0]  dtm_req_op,
  input  logic [31:0] dtm_req_data,
  output logic        dtm_resp_valid,
  input  logic        dtm_resp_ready,
  output logic [1:0]  dtm_resp_resp,
  output logic [31:0] dtm_resp_data,
  output logic        dmi_req_valid,
  input  logic        dmi_req_ready,
  output logic [6:0]  dmi_req_addr,
  output logic [1:0]  dmi_req_op,
  output logic [31:0] dmi_req_data,
  input  logic        dmi_resp_valid,
  output logic        dmi_resp_ready,
  input  logic [1:0]  dmi_resp_resp,
  input  logic [31:0] dmi_resp_data,
  output logic [15:0] timeout_count,
  output logic        busy
);

  localparam int unsigned PW       = $clog2(REQ_DEPTH);
  localparam int unsigned TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam bit            TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(REQ_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } req_t;

  state_e         state_q, state_d;
  req_t           mem_q [REQ_DEPTH];
  req_t           mem_d [REQ_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           ready_q, ready_d;
  req_t           cur_q, cur_d;
  logic [1:0]     resp_q, resp_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           stale_q, stale_d;
  logic [15:0]    tocnt_q, tocnt_d;
  logic           push, pop;
  req_t           head;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cur_d    = cur_q;
    resp_d   = resp_q;
    rdata_d  = rdata_q;
    timer_d  = timer_q;
    stale_d  = stale_q;
    tocnt_d  = tocnt_q;
    pop      = 1'b0;
    head     = mem_q[rd_ptr_q];
    push     = dtm_req_valid && ready_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{addr: dtm_req_addr, op: dtm_req_op, data: dtm_req_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && !stale_q) begin
          pop   = 1'b1;
          cur_d = head;
          case (head.op)
            2'd0: begin
              resp_d  = 2'd0;
              rdata_d = '0;
              state_d = ST_RESP;
            end
            2'd3: begin
              resp_d  = 2'd2;
              rdata_d = '0;
              state_d = ST_RESP;
            end
            default: state_d = ST_ISSUE;
          endcase
        end
      end
      ST_ISSUE: begin
        if (dmi_req_ready) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A response arriving on the expiry cycle takes priority over the timeout.
        if (dmi_resp_valid) begin
          resp_d  = dmi_resp_resp;
          rdata_d = dmi_resp_data;
          state_d = ST_RESP;
        end else if (TO_EN && (timer_q == T_LAST)) begin
          resp_d  = 2'd2;
          rdata_d = '0;
          stale_d = 1'b1;
          timer_d = '0;
          if (tocnt_q != 16'hFFFF) tocnt_d = tocnt_q + 16'd1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (dtm_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The timer is reused to age out a stale response; never overlaps WAIT.
    if (stale_q && (state_q != ST_WAIT)) begin
      if (dmi_resp_valid || (TO_EN && (timer_q == T_LAST))) begin
        stale_d = 1'b0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      for (int unsigned i = 0; i < REQ_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      cur_q    <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
      timer_q  <= '0;
      stale_q  <= 1'b0;
      tocnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      cur_q    <= cur_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      timer_q  <= timer_d;
      stale_q  <= stale_d;
      tocnt_q  <= tocnt_d;
    end
  end

  assign dtm_req_ready  = ready_q;
  assign dmi_req_valid  = (state_q == ST_ISSUE);
  assign dmi_req_addr   = cur_q.addr;
  assign dmi_req_op     = cur_q.op;
  assign dmi_req_data   = cur_q.data;
  assign dmi_resp_ready = (state_q == ST_WAIT) || stale_q;
  assign dtm_resp_valid = (state_q == ST_RESP);
  assign dtm_resp_resp  = resp_q;
  assign dtm_resp_data  = rdata_q;
  assign timeout_count  = tocnt_q;
  assign busy           = (count_q != '0) || (state_q != ST_IDLE);

endmodule
